// File: rtl/pio_in_edge.sv
// ---------------------------------------------------------------------------
// pio_in_edge
//
// Parametrised Avalon-MM input PIO. An asynchronous WIDTH-bit input bus is
// brought into the clock domain with a two-flop synchroniser, optionally
// debounced per bit, and watched for edges. Selected edges are latched in a
// sticky write-1-to-clear capture register that drives a maskable level
// interrupt.
//
// Optional feature macro: PIO_IN_DEBOUNCE_EN
//   defined   -> per-bit debounce counters; a bit of the filtered value
//                changes only after DEBOUNCE_CYCLES consecutive cycles in
//                which the synchronised input disagrees with it.
//   undefined -> the filtered value follows the synchroniser output directly.
//
// Register map (word addresses, read latency 1, zero-extended):
//   0 DATA     read-only filtered input
//   1 reserved reads 0
//   2 IRQMASK  read/write, WIDTH bits
//   3 EDGECAP  read, write 1 to clear a bit (a coincident new edge wins)
//
// Bus handshake: there is no wait-request. A transfer happens on every rising
// edge where chipselect is high together with read or write; readdata is
// valid during the cycle after the edge that sampled the read, and is zero
// otherwise.
//
// Ports:
//   clk        in   1      single clock, rising edge
//   reset      in   1      synchronous, active-high
//   address    in   2      word address
//   chipselect in   1      slave select
//   read       in   1      read strobe
//   write      in   1      write strobe
//   writedata  in   32     write data, bits above WIDTH ignored
//   in_port    in   WIDTH  asynchronous input pins
//   readdata   out  32     registered read data
//   irq        out  1      level interrupt, |(EDGECAP & IRQMASK)
// ---------------------------------------------------------------------------
module pio_in_edge #(
    parameter int WIDTH           = 8,
    parameter int EDGE_TYPE       = 0,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             read,
    input  logic             write,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_RSVD = 2'd1;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_CAP  = 2'd3;

    localparam logic [2:0] WARM_DONE = 3'd4;

    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;
    logic [WIDTH-1:0] r_filt;
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_cap;
    logic [WIDTH-1:0] r_irqmask;
    logic [2:0]       r_warm;
    logic [31:0]      r_readdata;

    logic             w_warm_done;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_edge_sel;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_wdata;
    logic [WIDTH-1:0] w_clr;
    logic             w_wr_mask;
    logic             w_wr_cap;
    logic             w_rd;
    logic [31:0]      w_rd_word;
    logic             w_unused_wdata;

    assign w_wdata        = writedata[WIDTH-1:0];
    assign w_unused_wdata = ^writedata;

    assign w_wr_mask = chipselect && write && (address == ADDR_MASK);
    assign w_wr_cap  = chipselect && write && (address == ADDR_CAP);
    assign w_rd      = chipselect && read;

    // -----------------------------------------------------------------------
    // Two-flop synchroniser and warm-up counter
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= in_port;
            r_s2 <= r_s1;
        end
    end

    // Warm-up lets the pipeline fill with the real input level before any
    // edge may be captured, so inputs held high through reset are not seen
    // as rising edges.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_warm <= '0;
        end else if (r_warm != WARM_DONE) begin
            r_warm <= r_warm + 3'd1;
        end
    end

    assign w_warm_done = (r_warm == WARM_DONE);

    // -----------------------------------------------------------------------
    // Filter stage
    // -----------------------------------------------------------------------
`ifdef PIO_IN_DEBOUNCE_EN
    localparam int             CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

    logic [CW-1:0] r_cnt [WIDTH];

    // The counter holds the number of consecutive cycles s2 has disagreed
    // with filt; the bit flips on the cycle that makes the run
    // DEBOUNCE_CYCLES long.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_filt <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else if (!w_warm_done) begin
            r_filt <= r_s2;
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (r_s2[i] != r_filt[i]) begin
                    if (r_cnt[i] == CNT_LAST) begin
                        r_filt[i] <= r_s2[i];
                        r_cnt[i]  <= '0;
                    end else begin
                        r_cnt[i] <= r_cnt[i] + CNT_ONE;
                    end
                end else begin
                    r_cnt[i] <= '0;
                end
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (reset) begin
            r_filt <= '0;
        end else begin
            r_filt <= r_s2;
        end
    end
`endif

    // -----------------------------------------------------------------------
    // Edge detection and capture
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev <= '0;
        end else begin
            r_prev <= r_filt;
        end
    end

    assign w_rise = r_filt & ~r_prev;
    assign w_fall = ~r_filt & r_prev;

    always_comb begin
        w_edge_sel = w_rise | w_fall;
        if (EDGE_TYPE == 0) begin
            w_edge_sel = w_rise;
        end else if (EDGE_TYPE == 1) begin
            w_edge_sel = w_fall;
        end
    end

    assign w_edge = w_warm_done ? w_edge_sel : '0;
    assign w_clr  = w_wr_cap ? w_wdata : '0;

    // Clear is applied before the OR so a coincident new edge keeps the bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cap <= '0;
        end else begin
            r_cap <= (r_cap & ~w_clr) | w_edge;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_irqmask <= '0;
        end else if (w_wr_mask) begin
            r_irqmask <= w_wdata;
        end
    end

    // -----------------------------------------------------------------------
    // Read path: registers are sampled before any same-edge write lands.
    // -----------------------------------------------------------------------
    always_comb begin
        w_rd_word = '0;
        case (address)
            ADDR_DATA: w_rd_word = 32'(r_filt);
            ADDR_RSVD: w_rd_word = '0;
            ADDR_MASK: w_rd_word = 32'(r_irqmask);
            ADDR_CAP:  w_rd_word = 32'(r_cap);
            default:   w_rd_word = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_readdata <= '0;
        end else if (w_rd) begin
            r_readdata <= w_rd_word;
        end else begin
            r_readdata <= '0;
        end
    end

    assign readdata = r_readdata;
    assign irq      = |(r_cap & r_irqmask);

endmodule

// File: tb/tb_pio_in_edge.sv
// ---------------------------------------------------------------------------
// tb_pio_in_edge
//
// Self-checking bench for pio_in_edge (WIDTH=8, rising edges, debounce of 4
// cycles when PIO_IN_DEBOUNCE_EN is defined). The reference model keeps the
// history of sampled input words and derives the filtered value, edges,
// capture register, mask and read data from that history after every edge.
// ---------------------------------------------------------------------------
module tb_pio_in_edge;

    localparam int W  = 8;
    localparam int ET = 0;
    localparam int DB = 4;
`ifdef PIO_IN_DEBOUNCE_EN
    localparam int DB_ON = 1;
`else
    localparam int DB_ON = 0;
`endif
    // Edges from a sampled input change to EDGECAP being set.
    localparam int CAP_LAT = (DB_ON != 0) ? (3 + DB - 1) : 3;

    // ---------------- clock / reset / DUT ----------------
    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    address;
    logic          chipselect;
    logic          read;
    logic          write;
    logic [31:0]   writedata;
    logic [W-1:0]  in_port;
    logic [31:0]   readdata;
    logic          irq;

    always #5 clk = ~clk;

    pio_in_edge #(
        .WIDTH           (W),
        .EDGE_TYPE       (ET),
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .read       (read),
        .write      (write),
        .writedata  (writedata),
        .in_port    (in_port),
        .readdata   (readdata),
        .irq        (irq)
    );

    // ---------------- scoreboard ----------------
    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // smp[k]  : input word sampled at edge k+1 after reset
    // fq[e]   : filtered value after edge e (fq[0] is the reset value)
    logic [W-1:0] smp[$];
    logic [W-1:0] fq[$];
    int           n;
    int           last_flip[W];
    logic [W-1:0] m_cap;
    logic [W-1:0] m_mask;
    logic [31:0]  m_rd;

    // Synchronised input as seen just before edge e: the word sampled two
    // edges earlier.
    function automatic logic [W-1:0] s2_before(input int e);
        if (e >= 3) return smp[e-3];
        return '0;
    endfunction

    function automatic logic [W-1:0] filt_after(input int e);
        if (e >= 0 && e < fq.size()) return fq[e];
        return '0;
    endfunction

    task automatic model_edge();
        logic [W-1:0] f_old;
        logic [W-1:0] p_old;
        logic [W-1:0] nf;
        logic [W-1:0] sv;
        logic [W-1:0] sel;
        logic [W-1:0] edg;
        logic [W-1:0] clr;
        logic         stable;
        if (reset) begin
            n = 0;
            smp.delete();
            fq.delete();
            fq.push_back('0);
            m_cap  = '0;
            m_mask = '0;
            m_rd   = '0;
            for (int i = 0; i < W; i++) last_flip[i] = 0;
            return;
        end
        n++;
        smp.push_back(in_port);
        f_old = filt_after(n - 1);
        p_old = filt_after(n - 2);

        m_rd = '0;
        if (chipselect && read) begin
            case (address)
                2'd0: m_rd = 32'(f_old);
                2'd2: m_rd = 32'(m_mask);
                2'd3: m_rd = 32'(m_cap);
                default: m_rd = '0;
            endcase
        end

        // Filtered value: direct during warm-up or without debounce;
        // otherwise a bit flips once its last DB post-warm-up samples,
        // all after its previous flip, disagree with it.
        if (DB_ON == 0 || n <= 4) begin
            nf = s2_before(n);
        end else begin
            nf = f_old;
            for (int i = 0; i < W; i++) begin
                if ((n - DB + 1) >= 5 && (n - DB + 1) > last_flip[i]) begin
                    stable = 1'b1;
                    for (int j = n - DB + 1; j <= n; j++) begin
                        sv = s2_before(j);
                        if (sv[i] == f_old[i]) stable = 1'b0;
                    end
                    if (stable) begin
                        nf[i]        = ~f_old[i];
                        last_flip[i] = n;
                    end
                end
            end
        end
        fq.push_back(nf);

        if (ET == 0)      sel = f_old & ~p_old;
        else if (ET == 1) sel = ~f_old & p_old;
        else              sel = f_old ^ p_old;
        edg = (n >= 5) ? sel : '0;

        clr = (chipselect && write && address == 2'd3) ? writedata[W-1:0] : '0;
        m_cap = (m_cap & ~clr) | edg;
        if (chipselect && write && address == 2'd2) m_mask = writedata[W-1:0];
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("readdata", readdata, m_rd);
        check("irq", {31'b0, irq}, {31'b0, |(m_cap & m_mask)});
    endtask

    task automatic idle(input int k);
        repeat (k) step();
    endtask

    task automatic bus(input logic rd, input logic wr, input logic [1:0] a, input logic [31:0] wd);
        chipselect = 1'b1;
        read       = rd;
        write      = wr;
        address    = a;
        writedata  = wd;
        step();
        chipselect = 1'b0;
        read       = 1'b0;
        write      = 1'b0;
        address    = 2'd0;
        writedata  = '0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset      = 1'b1;
        chipselect = 1'b0;
        read       = 1'b0;
        write      = 1'b0;
        address    = 2'd0;
        writedata  = '0;
        in_port    = 8'hFF;
        idle(2);
        check("reset_readdata", readdata, 32'h0);
        check("reset_irq", {31'b0, irq}, 32'h0);
        reset = 1'b0;

        // Input held high through reset: DATA follows, no edge captured.
        idle(12);
        bus(1'b1, 1'b0, 2'd0, '0);
        check("warm_data", readdata, 32'h0000_00FF);
        bus(1'b1, 1'b0, 2'd3, '0);
        check("warm_cap", readdata, 32'h0);
        check("warm_irq", {31'b0, irq}, 32'h0);

        // Rising edge on bit 0 with only bit 0 unmasked.
        bus(1'b0, 1'b1, 2'd2, 32'h1);
        in_port = 8'hFE;
        idle(12);
        in_port = 8'hFF;
        idle(CAP_LAT);
        check("rise_irq_before", {31'b0, irq}, 32'h0);
        step();
        check("rise_irq_after", {31'b0, irq}, 32'h1);
        bus(1'b1, 1'b0, 2'd3, '0);
        check("rise_cap", readdata, 32'h1);
        in_port = 8'hFE;
        idle(12);
        bus(1'b1, 1'b0, 2'd3, '0);
        check("fall_no_cap", readdata, 32'h1);

        // Clear lands on the same edge as a new rising edge on bit 0.
        in_port = 8'hFF;
        idle(CAP_LAT);
        bus(1'b0, 1'b1, 2'd3, 32'h1);
        check("race_irq", {31'b0, irq}, 32'h1);
        bus(1'b1, 1'b0, 2'd3, '0);
        check("race_cap", readdata, 32'h1);

        // Clear with nothing pending drops irq on the next cycle.
        bus(1'b0, 1'b1, 2'd3, 32'h1);
        check("clear_irq", {31'b0, irq}, 32'h0);
        bus(1'b0, 1'b1, 2'd2, 32'hFFFF_FF0F);
        bus(1'b1, 1'b0, 2'd2, '0);
        check("mask_readback", readdata, 32'h0000_000F);
        bus(1'b1, 1'b0, 2'd1, '0);
        check("reserved", readdata, 32'h0);

        // Reset while EDGECAP=05 and IRQMASK=FF.
        bus(1'b0, 1'b1, 2'd3, 32'hFF);
        bus(1'b0, 1'b1, 2'd2, 32'hFF);
        in_port = 8'h00;
        idle(12);
        in_port = 8'h05;
        idle(12);
        bus(1'b1, 1'b0, 2'd3, '0);
        check("pre_reset_cap", readdata, 32'h5);
        check("pre_reset_irq", {31'b0, irq}, 32'h1);
        reset = 1'b1;
        step();
        check("mid_reset_irq", {31'b0, irq}, 32'h0);
        reset = 1'b0;
        bus(1'b1, 1'b0, 2'd0, '0);
        check("post_reset_data", readdata, 32'h0);
        bus(1'b1, 1'b0, 2'd1, '0);
        check("post_reset_rsvd", readdata, 32'h0);
        bus(1'b1, 1'b0, 2'd2, '0);
        check("post_reset_mask", readdata, 32'h0);
        bus(1'b1, 1'b0, 2'd3, '0);
        check("post_reset_cap", readdata, 32'h0);

`ifdef PIO_IN_DEBOUNCE_EN
        // Short glitch on bit 2 is filtered; a long level passes.
        in_port = 8'h00;
        idle(12);
        in_port = 8'h04;
        idle(3);
        in_port = 8'h00;
        idle(12);
        bus(1'b1, 1'b0, 2'd0, '0);
        check("glitch_data", readdata, 32'h0);
        bus(1'b1, 1'b0, 2'd3, '0);
        check("glitch_cap", readdata, 32'h0);
        in_port = 8'h04;
        idle(9);
        bus(1'b1, 1'b0, 2'd0, '0);
        check("level_data", readdata, 32'h4);
        in_port = 8'h00;
        idle(12);
`endif

        // Randomised traffic, inputs and occasional resets.
        for (int c = 0; c < 1500; c++) begin
            reset = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 3) == 0) in_port = in_port ^ W'($urandom);
            chipselect = $urandom_range(0, 1) != 0;
            read       = $urandom_range(0, 1) != 0;
            write      = $urandom_range(0, 3) == 0;
            address    = 2'($urandom_range(0, 3));
            writedata  = $urandom;
            step();
        end
        reset      = 1'b0;
        chipselect = 1'b0;
        read       = 1'b0;
        write      = 1'b0;
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
